// File: rtl/fir_ffa_pkg.sv
// Shared types, constants and the output saturation helper for the
// 2-parallel fast-FIR (FFA) streaming filter.
package fir_ffa_pkg;

  localparam int unsigned DATA_IN_WIDTH_DEF = 16;
  localparam int unsigned TAP_WIDTH_DEF     = 32;
  localparam int unsigned ACC_WIDTH_DEF     = 64;

  // Input-to-output latency in clocks for an accepted beat.
  localparam int unsigned PIPE_LAT = 3;

  // Widest accumulator the saturation helper can handle.
  localparam int unsigned ACC_MAX = 128;

  typedef logic signed [DATA_IN_WIDTH_DEF-1:0] sample_t;
  typedef logic signed [DATA_IN_WIDTH_DEF:0]   sum_t;
  typedef logic signed [TAP_WIDTH_DEF-1:0]     tap_t;
  typedef logic signed [TAP_WIDTH_DEF:0]       tapsum_t;
  typedef logic signed [ACC_WIDTH_DEF-1:0]     acc_t;

  typedef enum logic {
    S_UNCFG = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // Symmetric clamp of a wide signed value to [-(2^(w-1)-1), 2^(w-1)-1].
  function automatic logic signed [ACC_MAX-1:0] sat_acc(
    input logic signed [ACC_MAX-1:0] a,
    input int unsigned               w
  );
    logic signed [ACC_MAX-1:0] max_v;
    logic signed [ACC_MAX-1:0] min_v;
    logic signed [ACC_MAX-1:0] res;
    max_v        = '0;
    max_v[w-1]   = 1'b1;
    max_v        = max_v - 1;
    min_v        = -max_v;
    res          = a;
    if (a > max_v) begin
      res = max_v;
    end else if (a < min_v) begin
      res = min_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_ffa_l2_stream_subfilter.sv
// Transposed-form M-tap sub-filter (fir_ffa_subfilter). Output is the
// registered head of the transposed adder chain; state advances only when
// en is high, so idle cycles do not shift zeros into the filter.
module fir_ffa_subfilter
  import fir_ffa_pkg::*;
#(
  parameter int unsigned X_WIDTH   = 16,
  parameter int unsigned T_WIDTH   = 32,
  parameter int unsigned ACC_WIDTH = 64,
  parameter int unsigned TAPS      = 51
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [X_WIDTH-1:0]   x,
  input  logic signed [T_WIDTH-1:0]   taps [TAPS],
  output logic signed [ACC_WIDTH-1:0] y
);

  localparam int unsigned P_WIDTH = X_WIDTH + T_WIDTH;

  logic signed [P_WIDTH-1:0]   prod [TAPS];
  logic signed [ACC_WIDTH-1:0] z_d  [TAPS];
  logic signed [ACC_WIDTH-1:0] z_q  [TAPS];

  // Full-precision products of the current sample with every tap.
  always_comb begin
    for (int unsigned i = 0; i < TAPS; i++) begin
      prod[i] = x * taps[i];
    end
  end

  // Transposed chain: each stage adds its product to the stage behind it.
  always_comb begin
    z_d = z_q;
    if (en) begin
      for (int unsigned i = 0; i < TAPS - 1; i++) begin
        z_d[i] = ACC_WIDTH'(prod[i]) + z_q[i+1];
      end
      z_d[TAPS-1] = ACC_WIDTH'(prod[TAPS-1]);
    end
  end

  // Chain registers; clear flushes the delay line.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        z_q[i] <= '0;
      end
    end else begin
      z_q <= z_d;
    end
  end

  assign y = z_q[0];

endmodule

// File: rtl/fir_ffa_l2_stream.sv
// 2-parallel FFA FIR with runtime-loadable, double-buffered taps.
// Three sub-filters (H0, H1, H0+H1) feed post-adders:
//   y0 = H0*x0 + D(H1*x1),  y1 = Hsum*(x0+x1) - H0*x0 - H1*x1.
// Optional build macro FIR_FFA_SAT_EN: symmetric output saturation in
// stage 3 when ACC_WIDTH > DATA_OUT_WIDTH; otherwise outputs wrap.
module fir_ffa_l2_stream
  import fir_ffa_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH  = 16,
  parameter int unsigned TAP_WIDTH      = 32,
  parameter int unsigned TAP_COUNT      = 102,
  parameter int unsigned ACC_WIDTH      = 64,
  parameter int unsigned DATA_OUT_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic signed [DATA_IN_WIDTH-1:0]  data_in_1,
  input  logic signed [DATA_IN_WIDTH-1:0]  data_in_2,
  input  logic                             clear,
  input  logic                             cfg_we,
  input  logic [$clog2(TAP_COUNT)-1:0]     cfg_addr,
  input  logic signed [TAP_WIDTH-1:0]      cfg_data,
  input  logic                             cfg_commit,
  output logic                             out_valid,
  output logic signed [DATA_OUT_WIDTH-1:0] data_out_1,
  output logic signed [DATA_OUT_WIDTH-1:0] data_out_2,
  output logic                             primed,
  output logic                             cfg_ready
);

  localparam int unsigned M     = TAP_COUNT / 2;
  localparam int unsigned CNT_W = $clog2(M + 1);

`ifdef FIR_FFA_SAT_EN
  localparam bit SAT_ON = (ACC_WIDTH > DATA_OUT_WIDTH);
`else
  localparam bit SAT_ON = 1'b0;
`endif

  if ((TAP_COUNT % 2) != 0) begin : g_bad_tap_count
    $error("fir_ffa_l2_stream: TAP_COUNT must be even");
  end
  if (DATA_OUT_WIDTH > ACC_WIDTH) begin : g_bad_out_width
    $error("fir_ffa_l2_stream: DATA_OUT_WIDTH must not exceed ACC_WIDTH");
  end
  if (ACC_WIDTH > ACC_MAX) begin : g_bad_acc_width
    $error("fir_ffa_l2_stream: ACC_WIDTH exceeds ACC_MAX");
  end

  state_t state_q, state_d;

  logic signed [TAP_WIDTH-1:0]      shadow_q [TAP_COUNT];
  logic signed [TAP_WIDTH-1:0]      shadow_d [TAP_COUNT];
  logic signed [TAP_WIDTH-1:0]      h0_q [M];
  logic signed [TAP_WIDTH-1:0]      h0_d [M];
  logic signed [TAP_WIDTH-1:0]      h1_q [M];
  logic signed [TAP_WIDTH-1:0]      h1_d [M];
  logic signed [TAP_WIDTH:0]        hs_q [M];
  logic signed [TAP_WIDTH:0]        hs_d [M];

  logic signed [DATA_IN_WIDTH-1:0]  x0_q, x0_d, x1_q, x1_d;
  logic signed [DATA_IN_WIDTH:0]    s_q, s_d;
  logic                             v1_q, v1_d, v2_q, v2_d;
  logic signed [ACC_WIDTH-1:0]      p0, p1, p2;
  logic signed [ACC_WIDTH-1:0]      d_q, d_d;
  logic signed [ACC_WIDTH-1:0]      y0_sum, y1_sum;
  logic signed [DATA_OUT_WIDTH-1:0] y0_q, y0_d, y1_q, y1_d;
  logic                             out_valid_q, out_valid_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;

  logic flush;
  logic accept;

  function automatic logic signed [DATA_OUT_WIDTH-1:0] fit_out(
    input logic signed [ACC_WIDTH-1:0] v
  );
    if (SAT_ON) begin
      return DATA_OUT_WIDTH'(sat_acc(ACC_MAX'(v), DATA_OUT_WIDTH));
    end
    return DATA_OUT_WIDTH'(v);
  endfunction

  assign flush  = clear || cfg_commit;
  assign accept = in_valid && (state_q == S_RUN) && !flush;

  // Configuration FSM: one-way transition to RUN on the first commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_UNCFG: if (cfg_commit) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_UNCFG;
    endcase
  end

  // Shadow writes and commit; the copy reads the pre-write shadow contents.
  always_comb begin
    shadow_d = shadow_q;
    h0_d     = h0_q;
    h1_d     = h1_q;
    hs_d     = hs_q;
    if (cfg_commit) begin
      for (int unsigned i = 0; i < M; i++) begin
        h0_d[i] = shadow_q[2*i];
        h1_d[i] = shadow_q[2*i+1];
        hs_d[i] = (TAP_WIDTH+1)'(shadow_q[2*i]) + (TAP_WIDTH+1)'(shadow_q[2*i+1]);
      end
    end
    if (cfg_we && (32'(cfg_addr) < TAP_COUNT)) begin
      shadow_d[cfg_addr] = cfg_data;
    end
  end

  // Stage 1: capture the sample pair and its sum, tag the beat.
  always_comb begin
    x0_d = x0_q;
    x1_d = x1_q;
    s_d  = s_q;
    v1_d = accept;
    v2_d = v1_q && !flush;
    if (accept) begin
      x0_d = data_in_1;
      x1_d = data_in_2;
      s_d  = (DATA_IN_WIDTH+1)'(data_in_1) + (DATA_IN_WIDTH+1)'(data_in_2);
    end
  end

  // Stage 2: the three sub-filters, advancing only on tagged beats.
  fir_ffa_subfilter #(
    .X_WIDTH(DATA_IN_WIDTH), .T_WIDTH(TAP_WIDTH), .ACC_WIDTH(ACC_WIDTH), .TAPS(M)
  ) u_sub_h0 (
    .clk(clk), .reset(reset), .clear(flush), .en(v1_q), .x(x0_q), .taps(h0_q), .y(p0)
  );

  fir_ffa_subfilter #(
    .X_WIDTH(DATA_IN_WIDTH), .T_WIDTH(TAP_WIDTH), .ACC_WIDTH(ACC_WIDTH), .TAPS(M)
  ) u_sub_h1 (
    .clk(clk), .reset(reset), .clear(flush), .en(v1_q), .x(x1_q), .taps(h1_q), .y(p1)
  );

  fir_ffa_subfilter #(
    .X_WIDTH(DATA_IN_WIDTH+1), .T_WIDTH(TAP_WIDTH+1), .ACC_WIDTH(ACC_WIDTH), .TAPS(M)
  ) u_sub_hs (
    .clk(clk), .reset(reset), .clear(flush), .en(v1_q), .x(s_q), .taps(hs_q), .y(p2)
  );

  // Stage 3: post-adders and the one-beat delay of the H1 branch.
  always_comb begin
    y0_sum      = p0 + d_q;
    y1_sum      = p2 - p0 - p1;
    d_d         = d_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    out_valid_d = v2_q && !flush;
    if (flush) begin
      d_d = '0;
    end else if (v2_q) begin
      d_d  = p1;
      y0_d = fit_out(y0_sum);
      y1_d = fit_out(y1_sum);
    end
  end

  // Primed counter: saturates at M accepted beats.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != CNT_W'(M))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // All state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_UNCFG;
      for (int unsigned i = 0; i < TAP_COUNT; i++) shadow_q[i] <= '0;
      for (int unsigned i = 0; i < M; i++) begin
        h0_q[i] <= '0;
        h1_q[i] <= '0;
        hs_q[i] <= '0;
      end
      x0_q        <= '0;
      x1_q        <= '0;
      s_q         <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      d_q         <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      hs_q        <= hs_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      s_q         <= s_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      d_q         <= d_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out_1 = y0_q;
  assign data_out_2 = y1_q;
  assign primed     = (cnt_q == CNT_W'(M));
  assign cfg_ready  = (state_q == S_RUN);

endmodule

// File: tb/tb_fir_ffa_l2_stream.sv
// Directed bench for fir_ffa_l2_stream (N=8). A direct-form reference FIR
// over the interleaved sample stream produces expected outputs, queued with
// their due cycle. A second instance with 32-bit outputs exercises the
// wrap / FIR_FFA_SAT_EN saturation path on the same stimulus.
module tb_fir_ffa_l2_stream;
  import fir_ffa_pkg::*;

  localparam int N = 8;
  localparam int M = N / 2;

  logic    clk = 1'b0;
  logic    reset, in_valid, clear, cfg_we, cfg_commit;
  sample_t data_in_1, data_in_2;
  logic [2:0] cfg_addr;
  tap_t    cfg_data;

  logic        out_valid, primed, cfg_ready;
  acc_t        data_out_1, data_out_2;
  logic        out_valid_w, primed_w, cfg_ready_w;
  logic signed [31:0] data_out_1_w, data_out_2_w;

  always #5 clk = ~clk;

  fir_ffa_l2_stream #(
    .DATA_IN_WIDTH(16), .TAP_WIDTH(32), .TAP_COUNT(N), .ACC_WIDTH(64), .DATA_OUT_WIDTH(64)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in_1(data_in_1),
    .data_in_2(data_in_2), .clear(clear), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .out_valid(out_valid),
    .data_out_1(data_out_1), .data_out_2(data_out_2), .primed(primed),
    .cfg_ready(cfg_ready)
  );

  fir_ffa_l2_stream #(
    .DATA_IN_WIDTH(16), .TAP_WIDTH(32), .TAP_COUNT(N), .ACC_WIDTH(64), .DATA_OUT_WIDTH(32)
  ) dut_w32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in_1(data_in_1),
    .data_in_2(data_in_2), .clear(clear), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .out_valid(out_valid_w),
    .data_out_1(data_out_1_w), .data_out_2(data_out_2_w), .primed(primed_w),
    .cfg_ready(cfg_ready_w)
  );

  typedef struct {
    int     due;
    longint y0;
    longint y1;
  } exp_t;

  exp_t   sb[$];
  longint hist[$];
  longint shadow[N];
  longint active[N];
  bit     running;
  int     primed_cnt;
  int     cyc;
  int     n_assert;
  int     n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic longint fir_at(int idx);
    longint acc;
    acc = 0;
    for (int k = 0; k < N; k++) begin
      if (idx - k >= 0) acc += active[k] * hist[idx-k];
    end
    return acc;
  endfunction

  function automatic logic [31:0] to32(longint e);
    logic [63:0] t;
`ifdef FIR_FFA_SAT_EN
    if (e > 64'sd2147483647) e = 64'sd2147483647;
    else if (e < -64'sd2147483647) e = -64'sd2147483647;
`endif
    t = e;
    return t[31:0];
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = (sb.size() > 0) && (sb[0].due == cyc);
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_valid_w32", 64'(out_valid_w), 64'(ev));
    chk("cfg_ready", 64'(cfg_ready), 64'(running));
    chk("primed", 64'(primed), 64'(primed_cnt == M));
    chk("primed_w32", 64'(primed_w), 64'(primed_cnt == M));
    if (ev) begin
      chk("y0", data_out_1, sb[0].y0);
      chk("y1", data_out_2, sb[0].y1);
      chk("y0_w32", {32'b0, data_out_1_w}, {32'b0, to32(sb[0].y0)});
      chk("y1_w32", {32'b0, data_out_2_w}, {32'b0, to32(sb[0].y1)});
      void'(sb.pop_front());
    end
  endtask

  task automatic step(input bit iv, input sample_t a, input sample_t b, input bit clr,
                      input bit we, input int addr, input tap_t data, input bit cmt,
                      input bit rst);
    bit   acc_beat;
    exp_t e;
    @(negedge clk);
    check_outputs();
    in_valid   = iv;
    data_in_1  = a;
    data_in_2  = b;
    clear      = clr;
    cfg_we     = we;
    cfg_addr   = 3'(addr);
    cfg_data   = data;
    cfg_commit = cmt;
    reset      = rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        shadow[k] = 0;
        active[k] = 0;
      end
      running    = 1'b0;
      primed_cnt = 0;
      hist.delete();
      sb.delete();
    end else begin
      acc_beat = iv && running && !clr && !cmt;
      if (cmt) begin
        for (int k = 0; k < N; k++) active[k] = shadow[k];
        running = 1'b1;
      end
      if (we && addr < N) shadow[addr] = longint'(data);
      if (clr || cmt) begin
        hist.delete();
        sb.delete();
        primed_cnt = 0;
      end
      if (acc_beat) begin
        hist.push_back(longint'(a));
        e.y0 = fir_at(hist.size() - 1);
        hist.push_back(longint'(b));
        e.y1 = fir_at(hist.size() - 1);
        e.due = cyc + PIPE_LAT - 1;
        sb.push_back(e);
        if (primed_cnt < M) primed_cnt++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic beat(input sample_t a, input sample_t b);
    step(1'b1, a, b, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic wtap(input int k, input tap_t v);
    step(1'b0, '0, '0, 1'b0, 1'b1, k, v, 1'b0, 1'b0);
  endtask

  task automatic commit();
    step(1'b0, '0, '0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0);
  endtask

  function automatic sample_t rnd_sample();
    return sample_t'(int'($urandom_range(0, 600)) - 300);
  endfunction

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0;
    running = 1'b0; primed_cnt = 0;
    for (int k = 0; k < N; k++) begin shadow[k] = 0; active[k] = 0; end
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    data_in_1 = '0; data_in_2 = '0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_y0", data_out_1, 0);
    chk("rst_y1", data_out_2, 0);
    chk("rst_primed", 64'(primed), 0);
    chk("rst_cfg_ready", 64'(cfg_ready), 0);

    // Unconfigured: load h[k]=k+1 while beats are offered and ignored.
    for (int k = 0; k < N; k++) step(1'b1, 16'sd1, 16'sd0, 1'b0, 1'b1, k, tap_t'(k + 1), 1'b0, 1'b0);
    beat(5, 5); beat(5, 5);
    idle(3);
    commit();
    idle(1);

    // Impulse on x0, then on x1.
    beat(1, 0); repeat (4) beat(0, 0); idle(4);
    beat(0, 1); repeat (4) beat(0, 0); idle(4);

    // Same impulse with two-cycle gaps between beats.
    beat(1, 0); idle(2);
    repeat (4) begin beat(0, 0); idle(2); end
    idle(3);

    // Random signed taps loaded while streaming; commit and write together.
    for (int k = 0; k < N; k++)
      step(1'($urandom_range(0, 1)), rnd_sample(), rnd_sample(), 1'b0, 1'b1, k,
           tap_t'(int'($urandom_range(0, 2000)) - 1000), 1'b0, 1'b0);
    step(1'b1, 16'sd4, 16'sd4, 1'b0, 1'b1, 0, tap_t'(77), 1'b1, 1'b0);
    repeat (12) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      beat(rnd_sample(), rnd_sample());
    end
    commit();
    repeat (6) beat(rnd_sample(), rnd_sample());
    idle(4);

    // Mid-stream reload to all-ones taps, then a unit step.
    for (int k = 0; k < N; k++) step(1'b1, 16'sd3, -16'sd2, 1'b0, 1'b1, k, tap_t'(1), 1'b0, 1'b0);
    step(1'b1, 16'sd3, -16'sd2, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0);
    repeat (6) beat(1, 1);
    idle(4);

    // Clear one cycle after an impulse; beat offered with clear is dropped.
    beat(1, 0);
    step(1'b1, 16'sd9, 16'sd9, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
    idle(4);
    beat(2, 3); beat(0, 0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
    idle(4);

    // Full-scale inputs and taps: exercises wrap or saturation at 32 bits.
    for (int k = 0; k < N; k++) wtap(k, 32'sh7FFFFFFF);
    commit();
    repeat (6) beat(16'sd32767, 16'sd32767);
    repeat (6) beat(-16'sd32768, -16'sd32768);
    idle(4);

    // Reset mid-stream clears everything, including the tap banks.
    beat(5, 6); beat(7, 8);
    step(1'b1, 16'sd1, 16'sd1, 1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    #1;
    chk("midrst_y0", data_out_1, 0);
    chk("midrst_y1", data_out_2, 0);
    chk("midrst_y0_w32", {32'b0, data_out_1_w}, 0);
    beat(1, 1); beat(1, 1);
    wtap(2, 3);
    commit();
    beat(1, 0); beat(0, 0); beat(0, 0);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
